// File: rtl/uart_pkg.sv
// Shared constants and the pacing FSM state type for the UART echo path.
package uart_pkg;

  localparam int unsigned BAUD_MAX_DEFAULT   = 115_200;
  localparam int unsigned CLK_MAX_DEFAULT    = 50_000_000;
  localparam int unsigned FRAME_BITS_DEFAULT = 11;
  localparam int unsigned DEPTH_DEFAULT      = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait
  } buf_state_e;

endpackage

// File: rtl/uart_byte_buffer_if.sv
// Byte-in / byte-out signals between uart_rx, the byte buffer and uart_tx.
interface uart_byte_buffer_if
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  pi_data;
  logic        pi_flag;
  logic [7:0]  po_data;
  logic        po_flag;
  logic [AW:0] fifo_count;
  logic        overflow;

  modport master (
    output pi_data,
    output pi_flag,
    input  po_data,
    input  po_flag,
    input  fifo_count,
    input  overflow
  );

  modport slave (
    input  pi_data,
    input  pi_flag,
    output po_data,
    output po_flag,
    output fifo_count,
    output overflow
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  // Full/empty come from the pre-edge count, so a push into a full FIFO is
  // dropped even when a pop lands on the same edge.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/uart_byte_buffer.sv
// Buffers received bytes and releases them to uart_tx one TX frame time apart.
module uart_byte_buffer
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_MAX   = BAUD_MAX_DEFAULT,
  parameter int unsigned CLK_MAX    = CLK_MAX_DEFAULT,
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEFAULT,
  parameter int unsigned DEPTH      = DEPTH_DEFAULT
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  uart_byte_buffer_if.slave bus
);

  localparam int unsigned BIT_CYCLES = CLK_MAX / BAUD_MAX;
  localparam int unsigned GAP_CYCLES = BIT_CYCLES * FRAME_BITS;
  localparam int unsigned AW         = $clog2(DEPTH);
  localparam int unsigned CNT_W      = $clog2(GAP_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 2);

  buf_state_e       state_q;
  logic [CNT_W-1:0] gap_cnt_q;
  logic [7:0]       po_data_q;
  logic             po_flag_q;
  logic             overflow_q;

  logic [7:0]       fifo_rdata;
  logic [AW:0]      fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  assign fifo_pop = (state_q == StIdle) && !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .push      (bus.pi_flag),
    .push_data (bus.pi_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The counter is 0 during SEND and already 1 on the first WAIT cycle; leaving
  // WAIT at GAP_CYCLES-2 puts the next pop exactly GAP_CYCLES after the last.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= StIdle;
      gap_cnt_q <= '0;
      po_data_q <= 8'h00;
      po_flag_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          po_flag_q <= 1'b0;
          if (!fifo_empty) begin
            state_q   <= StSend;
            po_data_q <= fifo_rdata;
            po_flag_q <= 1'b1;
            gap_cnt_q <= '0;
          end
        end
        StSend: begin
          po_flag_q <= 1'b0;
          gap_cnt_q <= gap_cnt_q + CNT_W'(1);
          state_q   <= StWait;
        end
        StWait: begin
          po_flag_q <= 1'b0;
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q   <= StIdle;
          po_flag_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= bus.pi_flag && fifo_full;
    end
  end

  assign bus.po_data    = po_data_q;
  assign bus.po_flag    = po_flag_q;
  assign bus.fifo_count = fifo_count;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_byte_buffer.sv
// Directed scoreboard bench for uart_byte_buffer with GAP_CYCLES = 110.
module tb_uart_byte_buffer;

  localparam int unsigned CLK_MAX    = 1000;
  localparam int unsigned BAUD_MAX   = 100;
  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned DEPTH      = 4;
  localparam int          GAP        = 110;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  uart_byte_buffer_if #(.DEPTH(DEPTH)) bus ();

  uart_byte_buffer #(
    .BAUD_MAX   (BAUD_MAX),
    .CLK_MAX    (CLK_MAX),
    .FRAME_BITS (FRAME_BITS),
    .DEPTH      (DEPTH)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         ovf_cnt = 0;
  int         max_cnt = 0;
  logic [7:0] exp_q[$];
  int         flag_cyc[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every po_flag pulse pops one expected byte from the scoreboard.
  initial forever begin
    @(posedge sys_clk);
    #1;
    if (bus.po_flag === 1'b1) begin
      flag_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_po_flag: got po_data %0h with nothing expected", bus.po_data);
      end else begin
        check("po_data", {24'h0, bus.po_data}, {24'h0, exp_q.pop_front()});
      end
    end
    if (bus.overflow === 1'b1) ovf_cnt++;
    if (int'(bus.fifo_count) > max_cnt) max_cnt = int'(bus.fifo_count);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  // Drives one pi_flag pulse; the sampling edge is the next rising edge.
  task automatic write_byte(input logic [7:0] d, input bit accept);
    @(negedge sys_clk);
    bus.pi_data = d;
    bus.pi_flag = 1'b1;
    if (accept) exp_q.push_back(d);
    @(posedge sys_clk);
    #1;
    bus.pi_flag = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_po_data"}, {24'h0, bus.po_data}, 32'h0);
    check({tag, "_po_flag"}, {31'h0, bus.po_flag}, 32'h0);
    check({tag, "_fifo_count"}, {29'h0, bus.fifo_count}, 32'h0);
    check({tag, "_overflow"}, {31'h0, bus.overflow}, 32'h0);
  endtask

  initial begin
    int nflags;
    bus.pi_data = 8'h00;
    bus.pi_flag = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_reset_outputs("reset");
    sys_rst = 1'b0;

    // Single byte: 2-cycle latency, one-cycle strobe.
    write_byte(8'hA5, 1'b1);
    check("single_flag_early", {31'h0, bus.po_flag}, 32'h0);
    check("single_count_1", {29'h0, bus.fifo_count}, 32'h1);
    @(posedge sys_clk);
    #1;
    check("single_flag", {31'h0, bus.po_flag}, 32'h1);
    check("single_data", {24'h0, bus.po_data}, 32'hA5);
    check("single_count_0", {29'h0, bus.fifo_count}, 32'h0);
    repeat (GAP + 5) @(posedge sys_clk);
    check("single_drained", exp_q.size(), 32'h0);

    // Burst: exact pacing between consecutive releases.
    flag_cyc.delete();
    max_cnt = 0;
    write_byte(8'h01, 1'b1);
    write_byte(8'h02, 1'b1);
    write_byte(8'h03, 1'b1);
    repeat (3 * GAP + 10) @(posedge sys_clk);
    check("burst_flags", flag_cyc.size(), 32'd3);
    if (flag_cyc.size() == 3) begin
      check("burst_gap1", flag_cyc[1] - flag_cyc[0], GAP);
      check("burst_gap2", flag_cyc[2] - flag_cyc[1], GAP);
    end
    check("burst_peak", {31'h0, (max_cnt >= 2 && max_cnt <= 3)}, 32'h1);
    check("burst_drained", exp_q.size(), 32'h0);

    // Overflow: FSM parked in WAIT while five bytes arrive into a depth-4 FIFO.
    ovf_cnt = 0;
    write_byte(8'h20, 1'b1);
    repeat (3) @(posedge sys_clk);
    write_byte(8'h10, 1'b1);
    write_byte(8'h11, 1'b1);
    write_byte(8'h12, 1'b1);
    write_byte(8'h13, 1'b1);
    write_byte(8'h14, 1'b0);
    check("ovf_pulse", {31'h0, bus.overflow}, 32'h1);
    check("ovf_count_full", {29'h0, bus.fifo_count}, 32'h4);
    repeat (5 * GAP + 20) @(posedge sys_clk);
    check("ovf_single_cycle", ovf_cnt, 32'h1);
    check("ovf_drained", exp_q.size(), 32'h0);

    // Wrap: slow trickle across the pointer boundary several times.
    flag_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      write_byte(8'h30 + 8'(i), 1'b1);
      repeat (GAP + 5) @(posedge sys_clk);
    end
    check("wrap_flags", flag_cyc.size(), 32'd10);
    check("wrap_drained", exp_q.size(), 32'h0);

    // Simultaneous push/pop with one byte stored.
    write_byte(8'h40, 1'b1);
    write_byte(8'h41, 1'b1);
    check("simul_count_a", {29'h0, bus.fifo_count}, 32'h1);
    repeat (GAP - 1) @(posedge sys_clk);
    write_byte(8'h42, 1'b1);
    check("simul_count_b", {29'h0, bus.fifo_count}, 32'h1);
    check("simul_flag_41", {31'h0, bus.po_flag}, 32'h1);
    check("simul_data_41", {24'h0, bus.po_data}, 32'h41);
    repeat (GAP) @(posedge sys_clk);
    #1;
    check("simul_flag_42", {31'h0, bus.po_flag}, 32'h1);
    check("simul_data_42", {24'h0, bus.po_data}, 32'h42);
    repeat (GAP + 5) @(posedge sys_clk);
    check("simul_drained", exp_q.size(), 32'h0);

    // Reset mid-WAIT with three bytes queued.
    write_byte(8'h50, 1'b1);
    write_byte(8'h51, 1'b0);
    write_byte(8'h52, 1'b0);
    write_byte(8'h53, 1'b0);
    check("rst_queued", {29'h0, bus.fifo_count}, 32'h3);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    @(negedge sys_clk);
    sys_rst = 1'b0;
    nflags = flag_cyc.size();
    repeat (200) @(posedge sys_clk);
    check("rst_silent", flag_cyc.size(), nflags);
    write_byte(8'h60, 1'b1);
    @(posedge sys_clk);
    #1;
    check("rst_resume_flag", {31'h0, bus.po_flag}, 32'h1);
    check("rst_resume_data", {24'h0, bus.po_data}, 32'h60);
    repeat (GAP + 5) @(posedge sys_clk);
    check("rst_drained", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
